mem_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for one MainMem port (14-bit word address, 18-bit data,
//  11 banks x 1024 words, 1-cycle synchronous read). Sits between the CPU data path (req0) and a

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single MainMem port.
// Serialises one transaction at a time, times read latency and flags unpopulated banks.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned NUM_BANKS = 11,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clka,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q;
    logic              last_gnt_q;
    logic              id_q;
    logic              we_q;
    logic              oor_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q [2];

    logic              any_valid;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_in_range;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        any_valid    = req0_valid | req1_valid;
        win          = (req0_valid & req1_valid) ? ~last_gnt_q : req1_valid;
        win_we       = win ? req1_we : req0_we;
        win_addr     = win ? req1_addr : req0_addr;
        win_wdata    = win ? req1_wdata : req0_wdata;
        win_in_range = 32'(win_addr[ADDR_W-1:10]) < NUM_BANKS;
    end

    assign req0_ready = (state_q == StIdle) && any_valid && !win;
    assign req1_ready = (state_q == StIdle) && any_valid && win;

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp0_rdata = rsp_rdata_q[0];
    assign rsp1_rdata = rsp_rdata_q[1];

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            last_gnt_q     <= 1'b1;
            id_q           <= 1'b0;
            we_q           <= 1'b0;
            oor_q          <= 1'b0;
            cnt_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_err_q      <= '0;
            rsp_rdata_q[0] <= '0;
            rsp_rdata_q[1] <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        id_q       <= win;
                        last_gnt_q <= win;
                        we_q       <= win_we;
                        oor_q      <= ~win_in_range;
                        mem_addr   <= win_addr;
                        mem_din    <= win_wdata;
                        mem_we     <= win_we & win_in_range;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    mem_we <= 1'b0;
                    if (oor_q || we_q) begin
                        rsp_err_q[id_q]   <= oor_q;
                        rsp_rdata_q[id_q] <= '0;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= StResp;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LAT);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 2'd1;
                    // Last wait cycle: the addressed word is on mem_dout now.
                    if (cnt_q == 2'd1) begin
                        rsp_err_q[id_q]   <= 1'b0;
                        rsp_rdata_q[id_q] <= mem_dout;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= StResp;
                    end
                end
                StResp: begin
                    rsp_valid_q <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle synchronous memory model.
module tb_mem_port_arbiter;

    logic        clka = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
    logic [13:0] req0_addr;
    logic [17:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
    logic [13:0] req1_addr;
    logic [17:0] req1_wdata, rsp1_rdata;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [17:0] mem_din, mem_dout;

    int tests  = 0;
    int failed = 0;

    logic [17:0] mem [0:16383];
    int          we_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0;
    logic [13:0] we_addr_last = '0;
    logic        bad_we = 1'b0;

    always #5 clka = ~clka;

    mem_port_arbiter dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always @(posedge clka) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(negedge clka) begin
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            we_addr_last <= mem_addr;
            if (mem_addr[13:10] >= 4'd11) bad_we <= 1'b1;
        end
        if (rsp0_valid) rsp0_cnt <= rsp0_cnt + 1;
        if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for acceptance, then count cycles from the accept cycle to rsp.
    task automatic txn(input logic id, input logic we, input logic [13:0] addr,
                       input logic [17:0] wd, output int lat, output logic [17:0] rd,
                       output logic er);
        int w;
        @(negedge clka);
        if (id) begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd;
        end else begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd;
        end
        w = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && w < 20) begin
            @(negedge clka);
            #1;
            w++;
        end
        chk("accept_timeout", 32'(w < 20), 32'd1);
        @(negedge clka);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!(id ? rsp1_valid : rsp0_valid) && lat < 20) begin
            @(negedge clka);
            lat++;
        end
        rd = id ? rsp1_rdata : rsp0_rdata;
        er = id ? rsp1_err : rsp0_err;
        #1;
    endtask

    initial begin
        int          lat, c0, c1, w0, g, cyc;
        logic [17:0] rd;
        logic        er;
        logic [7:0]  grants;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        #12;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_rsp_err", 32'({rsp1_err, rsp0_err}), 32'd0);
        chk("rst_rdata", 32'(rsp0_rdata | rsp1_rdata), 32'd0);
        @(negedge clka);
        rst_n = 1'b1;

        // 1: req0 write
        w0 = we_cnt;
        txn(1'b0, 1'b1, 14'h0005, 18'h2ABCD, lat, rd, er);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("t1_we_addr", 32'(we_addr_last), 32'h0005);

        // 2: req0 read back
        c1 = rsp1_cnt;
        txn(1'b0, 1'b0, 14'h0005, 18'h0, lat, rd, er);
        chk("t2_lat", 32'(lat), 32'd3);
        chk("t2_rdata", 32'(rd), 32'h2ABCD);
        chk("t2_err", 32'(er), 32'd0);
        chk("t2_no_rsp1", 32'(rsp1_cnt - c1), 32'd0);

        // req1 write used as data for the arbitration reads
        txn(1'b1, 1'b1, 14'h0010, 18'h01234, lat, rd, er);
        chk("t2b_lat", 32'(lat), 32'd2);

        // 3: reset so req0 wins the first tie, then both continuously valid
        @(negedge clka);
        rst_n = 1'b0;
        @(negedge clka);
        rst_n = 1'b1;
        #1;
        c0 = rsp0_cnt;
        c1 = rsp1_cnt;
        @(negedge clka);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 14'h0005;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 14'h0010;
        g = 0; cyc = 0; grants = '0;
        while (g < 8 && cyc < 200) begin
            #1;
            if (req0_ready) begin
                grants[g] = 1'b0; g++;
            end else if (req1_ready) begin
                grants[g] = 1'b1; g++;
            end
            @(negedge clka);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (8) @(negedge clka);
        #1;
        chk("t3_grant_count", 32'(g), 32'd8);
        chk("t3_grant_order", 32'(grants), 32'hAA);
        chk("t3_rsp0_pulses", 32'(rsp0_cnt - c0), 32'd4);
        chk("t3_rsp1_pulses", 32'(rsp1_cnt - c1), 32'd4);
        chk("t3_rsp0_rdata", 32'(rsp0_rdata), 32'h2ABCD);
        chk("t3_rsp1_rdata", 32'(rsp1_rdata), 32'h01234);

        // 4: out-of-range write, then last in-range word
        w0 = we_cnt;
        txn(1'b1, 1'b1, 14'h2C00, 18'h15555, lat, rd, er);
        chk("t4_lat", 32'(lat), 32'd2);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", 32'(rd), 32'd0);
        chk("t4_no_we", 32'(we_cnt - w0), 32'd0);
        chk("t4_bad_we", 32'(bad_we), 32'd0);
        txn(1'b1, 1'b1, 14'h2BFF, 18'h3FFFF, lat, rd, er);
        chk("t4b_err", 32'(er), 32'd0);
        chk("t4b_we_pulses", 32'(we_cnt - w0), 32'd1);

        // 5: reset during WAIT
        @(negedge clka);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 14'h0005;
        #1;
        chk("t5_ready", 32'(req0_ready), 32'd1);
        @(negedge clka);
        req0_valid = 1'b0;
        #1;
        chk("t5_issue_addr", 32'(mem_addr), 32'h0005);
        c0 = rsp0_cnt;
        @(negedge clka);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
        chk("t5_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("t5_rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
        chk("t5_rst_rsp1_err", 32'(rsp1_err), 32'd0);
        repeat (2) @(negedge clka);
        rst_n = 1'b1;
        repeat (3) @(negedge clka);
        #1;
        chk("t5_no_rsp", 32'(rsp0_cnt - c0), 32'd0);
        txn(1'b1, 1'b0, 14'h2BFF, 18'h0, lat, rd, er);
        chk("t5_after_lat", 32'(lat), 32'd3);
        chk("t5_after_rdata", 32'(rd), 32'h3FFFF);

        // 6: bank boundary
        txn(1'b0, 1'b1, 14'h03FF, 18'h11111, lat, rd, er);
        txn(1'b0, 1'b1, 14'h0400, 18'h22222, lat, rd, er);
        txn(1'b0, 1'b0, 14'h03FF, 18'h0, lat, rd, er);
        chk("t6_rd_03ff", 32'(rd), 32'h11111);
        txn(1'b0, 1'b0, 14'h0400, 18'h0, lat, rd, er);
        chk("t6_rd_0400", 32'(rd), 32'h22222);
        chk("t6_err", 32'(er), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
